mul_request_arbiter: RTL and testbench
======================================

Name: mul_request_arbiter

Overview:
- Shares one pipelined_array_multiplier instance between NUM_REQ independent requesters.
- Round-robin arbitration selects at most one operand pair per cycle and issues it to the multiplier.
- Each request's requester ID travels down a tag pipeline matched to the multiplier latency.
- Products return on a single tagged response channel; response backpressure freezes the multiplier and the tag pipeline together through the multiplier's clock enable.

Parameters:
- DATA_WIDTH, 16, operand width; must match the multiplier instance.
- PIPELINE_DEPTH, 4, multiplier depth; multiplier latency LAT = PIPELINE_DEPTH - 1 cycles; must be ≥ 2.
- NUM_REQ, 4, number of requesters, 2..16.
- ID_WIDTH, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_multiplicand_i  in  NUM_REQ*DATA_WIDTH  packed operand A, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
- req_multiplier_i  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing
- req_ready_o  out  NUM_REQ  one-hot (or zero) accept
- rsp_valid_o  out  1  product valid
- rsp_id_o  out  ID_WIDTH  requester owning the product
- rsp_product_o  out  2*DATA_WIDTH  product
- rsp_ready_i  in  1  response sink accepts
- mul_clk_en_o  out  1  multiplier clk_en_i
- mul_multiplicand_o  out  DATA_WIDTH  multiplier operand A
- mul_multiplier_o  out  DATA_WIDTH  multiplier operand B
- mul_valid_o  out  1  multiplier data_valid_i
- mul_product_i  in  2*DATA_WIDTH  multiplier product_o
- mul_valid_i  in  1  multiplier data_valid_o

Behaviour:
- Reset is asynchronous and clears:
  - rr_ptr to 0 and all tag stages to 0;
  - req_ready_o to 0, rsp_valid_o to 0, mul_valid_o to 0;
  - mul_clk_en_o to 1.
- The multiplier shares rst_n_i. Reset mid-operation discards all in-flight products; nothing is replayed.
- stall = mul_valid_i & ~rsp_ready_i.
  - mul_clk_en_o = ~stall (combinational).
  - Tag pipeline and rr_ptr advance only when ~stall.
- Arbitration (combinational): search req_valid_i starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit is the grant g.
  - req_ready_o[g] = ~stall; all other bits are 0.
  - With no valid request there is no grant and req_ready_o = 0.
- Issue: mul_valid_o = any valid & ~stall.
  - mul_multiplicand_o and mul_multiplier_o carry requester g's operands, or 0 when idle.
  - The request handshake completes when req_valid_i[k] & req_ready_o[k].
- Pointer: on issue, rr_ptr <= (g + 1) mod NUM_REQ, including the wrap from NUM_REQ-1 to 0. With no issue, rr_ptr holds.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 issues.
- Tag pipeline: LAT stages of {valid, id}.
  - Stage 0 loads {mul_valid_o, g}; stage j loads stage j-1.
  - The last stage pairs with mul_product_i.
- Response:
  - rsp_valid_o = mul_valid_i.
  - rsp_product_o = mul_product_i.
  - rsp_id_o = last tag id.
- Latency: issue at cycle t gives rsp_valid_o at cycle t+LAT when there are no stalls; each stall cycle adds one cycle.
- Throughput: one issue per cycle when ~stall.
- A stall and a new request in the same cycle: the request is not accepted, its operands are held by the requester, and the pointer is unchanged.
- Stall with an empty pipeline is impossible, because stall requires mul_valid_i.
- Consistency assertion (simulation only): mul_valid_i must equal the last tag valid.
- Requesters may drop req_valid_i before being granted. No stickiness is required.

Optional Feature:
- Macro: MUL_ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_busy_cnt_o, 32 bits: counts cycles with mul_valid_o = 1.
  - Adds output perf_stall_cnt_o, 32 bits: counts cycles with stall = 1.
  - Both counters saturate at all-ones, reset to 0, and are cleared synchronously by an added input perf_clr_i. perf_clr_i takes priority over increment.
- When undefined: none of these ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Package mul_arb_pkg holds:
  - localparam function LAT(depth) = depth - 1;
  - typedef tag_t, a packed struct {logic valid; logic [ID_WIDTH-1:0] id;}.
- Sub-module rr_arbiter, parameterized by NUM_REQ:
  - inputs req, ptr, en;
  - outputs grant_onehot, grant_idx, any;
  - purely combinational, with the pointer register kept in the parent.

Test Plan:
- Single requester 1 issues 0xFFFF × 0xFFFF → after LAT=3 cycles rsp_valid_o=1, rsp_id_o=1, rsp_product_o=0xFFFE0001.
- All 4 requesters valid continuously, rsp_ready_i=1 → grants cycle 0,1,2,3,0…; responses arrive back-to-back with ids 0,1,2,3 and correct products.
- rr_ptr=3 with only requesters 3 and 0 valid → requester 3 is granted and then 0 (wrap); rr_ptr ends at 1.
- rsp_ready_i held low 5 cycles while a response is pending → mul_clk_en_o=0, req_ready_o=0, rsp_valid_o/id/product stable for all 5 cycles; pipeline resumes with no loss or duplication when rsp_ready_i rises.
- rst_n_i asserted mid-stream with 3 products in flight → all outputs go to reset values immediately (async); after release no stale rsp_valid_o appears, and the first grant goes to requester 0.
- MUL_ARB_PERF_CNT_EN defined: 10 issues plus 4 stall cycles → perf_busy_cnt_o=10, perf_stall_cnt_o=4; perf_clr_i pulse → both read 0 on the next cycle.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier request arbiter.
// Tag ids are sized for the largest supported requester count (16).
package mul_arb_pkg;

    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int LAT(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// The pointer register lives in the parent so it can be frozen by a stall.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    input  logic                i_en,
    output logic [NUM_REQ-1:0]  o_grant_onehot,
    output logic [ID_WIDTH-1:0] o_grant_idx,
    output logic                o_any
);

    logic w_found;
    int   w_idx;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = int'(i_ptr) + off;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found     = 1'b1;
                o_grant_idx = ID_WIDTH'(w_idx);
            end
        end
    end

    assign o_any          = |i_req;
    assign o_grant_onehot = (i_en && o_any) ? (NUM_REQ'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/mul_request_arbiter.sv
// Shares one external pipelined multiplier between NUM_REQ requesters with tagged responses.
// Optional perf counters: define MUL_ARB_PERF_CNT_EN.
module mul_request_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int PIPELINE_DEPTH = 4,
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_multiplicand_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_multiplier_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [2*DATA_WIDTH-1:0]       rsp_product_o,
    input  logic                          rsp_ready_i,
    output logic                          mul_clk_en_o,
    output logic [DATA_WIDTH-1:0]         mul_multiplicand_o,
    output logic [DATA_WIDTH-1:0]         mul_multiplier_o,
    output logic                          mul_valid_o,
    input  logic [2*DATA_WIDTH-1:0]       mul_product_i,
    input  logic                          mul_valid_i
`ifdef MUL_ARB_PERF_CNT_EN
    ,
    input  logic                          perf_clr_i,
    output logic [31:0]                   perf_busy_cnt_o,
    output logic [31:0]                   perf_stall_cnt_o
`endif
);

    import mul_arb_pkg::*;

    localparam int LAT_C = LAT(PIPELINE_DEPTH);

    logic                w_stall;
    logic                w_run;
    logic                w_any;
    logic                w_issue;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_WIDTH-1:0] w_grant_idx;
    logic [ID_WIDTH-1:0] w_ptr_next;
    logic [ID_WIDTH-1:0] r_rr_ptr;
    tag_t                r_tag [LAT_C];

    // A held response freezes multiplier, tags and pointer together; reset forces the idle values.
    assign w_stall      = mul_valid_i & ~rsp_ready_i;
    assign w_run        = rst_n_i & ~w_stall;
    assign mul_clk_en_o = ~w_stall | ~rst_n_i;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .i_req          (req_valid_i),
        .i_ptr          (r_rr_ptr),
        .i_en           (w_run),
        .o_grant_onehot (w_grant),
        .o_grant_idx    (w_grant_idx),
        .o_any          (w_any)
    );

    assign req_ready_o = w_grant;
    assign w_issue     = w_any & w_run;
    assign mul_valid_o = w_issue;
    assign w_ptr_next  = (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        mul_multiplicand_o = '0;
        mul_multiplier_o   = '0;
        if (w_any) begin
            mul_multiplicand_o = req_multiplicand_i[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            mul_multiplier_o   = req_multiplier_i[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n_i)     r_rr_ptr <= '0;
        else if (w_issue) r_rr_ptr <= w_ptr_next;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the tag stages are reset, not left random, so a reset cannot release a stale response.
            for (int j = 0; j < LAT_C; j++) r_tag[j] <= '0;
        end else if (!w_stall) begin
            r_tag[0] <= tag_t'{valid: w_issue, id: TAG_ID_W'(w_grant_idx)};
            for (int j = 1; j < LAT_C; j++) r_tag[j] <= r_tag[j-1];
        end
    end

    assign rsp_valid_o   = mul_valid_i;
    assign rsp_product_o = mul_product_i;
    assign rsp_id_o      = r_tag[LAT_C-1].id[ID_WIDTH-1:0];

`ifndef SYNTHESIS
    a_tag_sync: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        mul_valid_i == r_tag[LAT_C-1].valid);
`endif

`ifdef MUL_ARB_PERF_CNT_EN
    logic [31:0] r_busy_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
        end else if (perf_clr_i) begin
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_issue && !(&r_busy_cnt))  r_busy_cnt  <= r_busy_cnt + 32'd1;
            if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_busy_cnt_o  = r_busy_cnt;
    assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mul_request_arbiter.sv
// Bench: behavioural multiplier, per-cycle scoreboard of grants/responses, directed scenarios.
// Perf-counter scenario is included when MUL_ARB_PERF_CNT_EN is defined.
module tb_mul_request_arbiter;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int NR    = 4;
    localparam int IDW   = 2;
    localparam int LAT   = DEPTH - 1;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR*DW-1:0]  req_multiplicand_i;
    logic [NR*DW-1:0]  req_multiplier_i;
    logic [NR-1:0]     req_ready_o;
    logic              rsp_valid_o;
    logic [IDW-1:0]    rsp_id_o;
    logic [2*DW-1:0]   rsp_product_o;
    logic              rsp_ready_i;
    logic              mul_clk_en_o;
    logic [DW-1:0]     mul_multiplicand_o;
    logic [DW-1:0]     mul_multiplier_o;
    logic              mul_valid_o;
    logic [2*DW-1:0]   mul_product_i;
    logic              mul_valid_i;
`ifdef MUL_ARB_PERF_CNT_EN
    logic              perf_clr_i;
    logic [31:0]       perf_busy_cnt_o;
    logic [31:0]       perf_stall_cnt_o;
`endif

    logic [DW-1:0] op_a [NR];
    logic [DW-1:0] op_b [NR];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            req_multiplicand_i[k*DW +: DW] = op_a[k];
            req_multiplier_i[k*DW +: DW]   = op_b[k];
        end
    end

    mul_request_arbiter #(
        .DATA_WIDTH     (DW),
        .PIPELINE_DEPTH (DEPTH),
        .NUM_REQ        (NR),
        .ID_WIDTH       (IDW)
    ) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .req_valid_i        (req_valid_i),
        .req_multiplicand_i (req_multiplicand_i),
        .req_multiplier_i   (req_multiplier_i),
        .req_ready_o        (req_ready_o),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_id_o           (rsp_id_o),
        .rsp_product_o      (rsp_product_o),
        .rsp_ready_i        (rsp_ready_i),
        .mul_clk_en_o       (mul_clk_en_o),
        .mul_multiplicand_o (mul_multiplicand_o),
        .mul_multiplier_o   (mul_multiplier_o),
        .mul_valid_o        (mul_valid_o),
        .mul_product_i      (mul_product_i),
        .mul_valid_i        (mul_valid_i)
`ifdef MUL_ARB_PERF_CNT_EN
        ,
        .perf_clr_i         (perf_clr_i),
        .perf_busy_cnt_o    (perf_busy_cnt_o),
        .perf_stall_cnt_o   (perf_stall_cnt_o)
`endif
    );

    // Behavioural stand-in for the pipelined multiplier: LAT stages, frozen by clk_en.
    logic [2*DW-1:0] m_p [LAT];
    logic            m_v [LAT];

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < LAT; j++) begin
                m_p[j] <= '0;
                m_v[j] <= 1'b0;
            end
        end else if (mul_clk_en_o) begin
            m_p[0] <= 32'(mul_multiplicand_o) * 32'(mul_multiplier_o);
            m_v[0] <= mul_valid_o;
            for (int j = 1; j < LAT; j++) begin
                m_p[j] <= m_p[j-1];
                m_v[j] <= m_v[j-1];
            end
        end
    end

    assign mul_product_i = m_p[LAT-1];
    assign mul_valid_i   = m_v[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: each issue is due LAT non-stalled cycles later; responses leave in issue order.
    typedef struct {
        int          id;
        logic [31:0] prod;
        int          due;
    } rsp_t;

    rsp_t          exp_q [$];
    int            m_ptr = 0;
    int            m_act = 0;
    int            m_g;
    int            m_idx;
    logic          m_rv;
    logic          m_stall;
    logic [NR-1:0] m_ready;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            exp_q.delete();
            m_ptr = 0;
            m_act = 0;
            check("rst_req_ready", 64'(req_ready_o), 64'd0);
            check("rst_mul_valid", 64'(mul_valid_o), 64'd0);
            check("rst_clk_en",    64'(mul_clk_en_o), 64'd1);
            check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        end else begin
            m_rv    = (exp_q.size() > 0) && (exp_q[0].due == m_act);
            m_stall = m_rv && !rsp_ready_i;
            m_g     = -1;
            for (int off = 0; off < NR; off++) begin
                m_idx = (m_ptr + off) % NR;
                if (m_g < 0 && req_valid_i[m_idx]) m_g = m_idx;
            end
            m_ready = '0;
            if (m_g >= 0 && !m_stall) m_ready[m_g] = 1'b1;
            m_a = (m_g >= 0) ? op_a[m_g] : '0;
            m_b = (m_g >= 0) ? op_b[m_g] : '0;

            check("req_ready",  64'(req_ready_o),        64'(m_ready));
            check("mul_valid",  64'(mul_valid_o),        64'(m_g >= 0 && !m_stall));
            check("clk_en",     64'(mul_clk_en_o),       64'(!m_stall));
            check("mul_a",      64'(mul_multiplicand_o), 64'(m_a));
            check("mul_b",      64'(mul_multiplier_o),   64'(m_b));
            check("rsp_valid",  64'(rsp_valid_o),        64'(m_rv));
            if (m_rv) begin
                check("rsp_id",      64'(rsp_id_o),      64'(exp_q[0].id));
                check("rsp_product", 64'(rsp_product_o), 64'(exp_q[0].prod));
                if (rsp_ready_i) void'(exp_q.pop_front());
            end
            if (!m_stall) begin
                if (m_g >= 0) begin
                    exp_q.push_back('{m_g, 32'(m_a) * 32'(m_b), m_act + LAT});
                    m_ptr = (m_g + 1) % NR;
                end
                m_act++;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i     = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < NR; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
`ifdef MUL_ARB_PERF_CNT_EN
        perf_clr_i = 1'b0;
`endif
        step();
        step();
        rst_n_i = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready_o), 64'd0);

        // Single requester 1: 0xFFFF * 0xFFFF after three cycles.
        op_a[1] = 16'hFFFF;
        op_b[1] = 16'hFFFF;
        req_valid_i = 4'b0010;
        #1;
        check("t1_ready", 64'(req_ready_o), 64'h2);
        step();
        req_valid_i = '0;
        #1;
        check("t1_lat1", 64'(rsp_valid_o), 64'd0);
        step();
        check("t1_lat2", 64'(rsp_valid_o), 64'd0);
        step();
        check("t1_valid", 64'(rsp_valid_o),   64'd1);
        check("t1_id",    64'(rsp_id_o),      64'd1);
        check("t1_prod",  64'(rsp_product_o), 64'hFFFE0001);
        repeat (3) step();

        // Fresh reset, then all four requesters continuously.
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        op_a[0] = 16'h1234; op_b[0] = 16'h0010;
        op_a[1] = 16'h8000; op_b[1] = 16'h0002;
        op_a[2] = 16'hFFFF; op_b[2] = 16'h0002;
        op_a[3] = 16'h0001; op_b[3] = 16'hABCD;
        req_valid_i = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("t2_grant", 64'(req_ready_o), 64'(4'b0001 << (i % 4)));
            if (i >= LAT) begin
                check("t2_rsp_valid", 64'(rsp_valid_o), 64'd1);
                check("t2_rsp_id",    64'(rsp_id_o),    64'((i - LAT) % 4));
            end
            step();
        end
        req_valid_i = '0;
        repeat (4) step();

        // Pointer at 3 with requesters 3 and 0: wrap, then pointer lands on 1.
        req_valid_i = 4'b0100;
        #1;
        check("t3_set_ptr", 64'(req_ready_o), 64'h4);
        step();
        req_valid_i = 4'b1001;
        #1;
        check("t3_grant3", 64'(req_ready_o), 64'h8);
        step();
        check("t3_grant0", 64'(req_ready_o), 64'h1);
        step();
        req_valid_i = 4'b1111;
        #1;
        check("t3_ptr1", 64'(req_ready_o), 64'h2);
        step();
        req_valid_i = '0;
        repeat (4) step();

        // Response backpressure for 5 cycles with a competing request.
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b1111;
        #1;
        check("t4_g2", 64'(req_ready_o), 64'h4);
        step();
        check("t4_g3", 64'(req_ready_o), 64'h8);
        step();
        check("t4_g0", 64'(req_ready_o), 64'h1);
        step();
        req_valid_i = 4'b0010;
        #1;
        for (int s = 0; s < 5; s++) begin
            check("t4_clk_en", 64'(mul_clk_en_o),  64'd0);
            check("t4_ready",  64'(req_ready_o),   64'd0);
            check("t4_valid",  64'(rsp_valid_o),   64'd1);
            check("t4_id",     64'(rsp_id_o),      64'd2);
            check("t4_prod",   64'(rsp_product_o), 64'h0001FFFE);
            step();
        end
        rsp_ready_i = 1'b1;
        #1;
        check("t4_resume_g1", 64'(req_ready_o), 64'h2);
        check("t4_resume_id", 64'(rsp_id_o),    64'd2);
        step();
        req_valid_i = '0;
        #1;
        check("t4_next_id3", 64'(rsp_id_o), 64'd3);
        step();
        check("t4_next_id0", 64'(rsp_id_o), 64'd0);
        step();
        check("t4_next_id1", 64'(rsp_id_o), 64'd1);
        repeat (3) step();

        // Asynchronous reset with three products in flight.
        req_valid_i = 4'b1111;
        repeat (3) step();
        check("t5_inflight", 64'(rsp_valid_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        check("t5_async_ready", 64'(req_ready_o),  64'd0);
        check("t5_async_mulv",  64'(mul_valid_o),  64'd0);
        check("t5_async_clken", 64'(mul_clk_en_o), 64'd1);
        check("t5_async_rspv",  64'(rsp_valid_o),  64'd0);
        step();
        step();
        rst_n_i = 1'b1;
        #1;
        check("t5_first_grant", 64'(req_ready_o), 64'h1);
        for (int c = 0; c < LAT; c++) begin
            check("t5_no_stale", 64'(rsp_valid_o), 64'd0);
            step();
        end
        req_valid_i = '0;
        repeat (5) step();

`ifdef MUL_ARB_PERF_CNT_EN
        perf_clr_i = 1'b1;
        step();
        perf_clr_i = 1'b0;
        #1;
        check("perf_clr_busy",  64'(perf_busy_cnt_o),  64'd0);
        check("perf_clr_stall", 64'(perf_stall_cnt_o), 64'd0);
        req_valid_i = 4'b1111;
        repeat (10) step();
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        repeat (4) step();
        rsp_ready_i = 1'b1;
        repeat (5) step();
        check("perf_busy",  64'(perf_busy_cnt_o),  64'd10);
        check("perf_stall", 64'(perf_stall_cnt_o), 64'd4);
        perf_clr_i = 1'b1;
        step();
        perf_clr_i = 1'b0;
        #1;
        check("perf_clr2_busy",  64'(perf_busy_cnt_o),  64'd0);
        check("perf_clr2_stall", 64'(perf_stall_cnt_o), 64'd0);
`endif

        step();
        check("all_rsp_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
